key_debounce_pulse: RTL and testbench
=====================================

Name: key_debounce_pulse

Overview:
Front-end conditioning stage for the board push-buttons. Takes raw, bouncing, asynchronous key inputs and synchronises and debounces each key independently. Emits a single-cycle press pulse per key that directly drives the key-toggle stage's Key_Input bus. Also exports the debounced key level for status/LED use.

Parameters:
NKEYS, 5, number of independent keys
DEBOUNCE_CYCLES, 1000000, stable-sample count required to accept a level change (20 ms at 50 MHz); legal range >= 2
KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = raw key reads 1 when pressed

Ports:
CLK  in  1  system clock
RSTn  in  1  asynchronous active-low reset
Key_In  in  NKEYS  raw key pins, asynchronous to CLK, may bounce
Key_Pulse  out  NKEYS  one-CLK-cycle high pulse per accepted press, bit i for key i
Key_Level  out  NKEYS  debounced key state, 1 = pressed

Behaviour:
- Reset: CLK and RSTn as decided (reset RSTn, asynchronous, active-low; clock CLK).
- Reset values: Key_Pulse = 0, Key_Level = 0, all counters = 0, all key FSMs in UP.
- Reset values, synchroniser: both synchroniser flops per key preset to the released level (1 if KEY_ACTIVE_LOW, else 0).
- Input conditioning: each Key_In bit passes through a 2-flop synchroniser, then is normalised to "pressed" = 1 (inverted when KEY_ACTIVE_LOW=1).
- Per-key counter width: clog2(DEBOUNCE_CYCLES). Counter is unsigned, never wraps; it is cleared on every state entry.
- Per-key FSM, UP: Key_Level=0. Synced pressed -> WAIT_DN, cnt=0.
- Per-key FSM, WAIT_DN: synced released -> UP, cnt=0 (bounce rejected, no pulse). Else if cnt == DEBOUNCE_CYCLES-1 -> DOWN, assert Key_Pulse for exactly one cycle, Key_Level=1. Else cnt+1.
- Per-key FSM, DOWN: Key_Level=1. Synced released -> WAIT_UP, cnt=0.
- Per-key FSM, WAIT_UP: synced pressed -> DOWN, cnt=0 (no new pulse). Else if cnt == DEBOUNCE_CYCLES-1 -> UP, Key_Level=0. Else cnt+1.
- Release produces no pulse.
- Latency: raw press first sampled at clock edge E0 and held stable -> Key_Pulse and Key_Level rise at edge E0+2+DEBOUNCE_CYCLES. Release latency is symmetric for Key_Level.
- Pulse width: exactly 1 cycle. Holding a key never repeats the pulse. A new pulse requires a full debounced release followed by a full debounced press.
- Simultaneous presses: keys are fully independent. Multiple Key_Pulse bits may assert in the same cycle, with no prioritisation in this block (the downstream toggle stage resolves priority).
- Outputs are registered; there is no combinational path from Key_In to any output.
- Reset mid-operation: all state is discarded. A key still held when RSTn deasserts is treated as a fresh press and pulses after the full latency measured from the first post-reset sampling edge.

Decomposition:
- Shared package holds the FSM state encoding (UP, WAIT_DN, DOWN, WAIT_UP; 2-bit localparams) and the counter-width function.
- One natural sub-module, key_debounce_one: synchroniser + FSM + counter for a single key, with DEBOUNCE_CYCLES and KEY_ACTIVE_LOW passed down.
- The top instantiates key_debounce_one NKEYS times via a generate loop.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1, NKEYS=5.)
1. Reset: RSTn low with Key_In=5'b00000 -> Key_Pulse=0 and Key_Level=0 throughout. Release RSTn with Key_In=5'b11111 -> outputs remain 0 for 20 cycles.
2. Clean press: Key_In[0] goes 0 before edge E0 and is held 20 cycles -> Key_Pulse=5'b00001 for one cycle starting at E0+6. Key_Level[0]=1 from E0+6. No further pulses while held.
3. Bouncy press: Key_In[2] toggles every 2 cycles for 12 cycles, then is held low, with final low first sampled at edge E1 -> exactly one pulse on bit 2 at E1+6.
4. Short glitch: Key_In[3] low for 3 cycles, then high -> no pulse, Key_Level[3] stays 0.
5. Simultaneous press: Key_In[4] and Key_In[1] go low before the same edge E0 -> Key_Pulse=5'b10010 in the single cycle starting at E0+6.
6. Release/re-press and reset: after an accepted press on key 0, release for 2 cycles then press again -> no second pulse, Key_Level[0] stays 1. Separately, assert RSTn mid-WAIT_DN with the key held -> outputs clear immediately; a pulse follows 6 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/key_debounce_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_pulse_pkg
// Brief    : Shared definitions for the push-button debounce stage: per-key
//            FSM state encoding and the debounce counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package key_debounce_pulse_pkg;

  // Per-key debounce FSM state, explicitly 2 bits wide.
  typedef logic [1:0] key_state_t;

  // Key released and stable.
  localparam key_state_t c_ST_UP      = 2'd0;
  // Press seen, waiting for it to stay stable long enough.
  localparam key_state_t c_ST_WAIT_DN = 2'd1;
  // Key pressed and stable.
  localparam key_state_t c_ST_DOWN    = 2'd2;
  // Release seen, waiting for it to stay stable long enough.
  localparam key_state_t c_ST_WAIT_UP = 2'd3;

  // Counter width that can hold 0 .. cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : key_debounce_pulse_pkg
`default_nettype wire

// File: rtl/key_debounce_one.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_one
// Brief    : Single-key conditioning: 2-flop synchroniser, polarity
//            normalisation, and a four-state debounce FSM with a stability
//            counter. Produces a registered one-cycle press pulse and a
//            registered debounced level (1 = pressed).
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_one
  import key_debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic key_raw,
  output logic key_pulse,
  output logic key_level
);

  localparam int               CNT_W      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  // Raw pin level when the key is not pressed; also the synchroniser preset
  // so that reset release never looks like an edge.
  localparam logic             c_RELEASED = KEY_ACTIVE_LOW;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_pressed;

  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_pulse_nxt;
  logic             w_level_nxt;
  logic             r_pulse;
  logic             r_level;

  // Two-flop synchroniser for the asynchronous, bouncing key pin.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1 <= c_RELEASED;
      r_sync2 <= c_RELEASED;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Normalise polarity: 1 means the key is currently pressed.
  assign w_pressed = r_sync2 ^ c_RELEASED;

  // State register, stability counter and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= c_ST_UP;
      r_cnt   <= c_CNT_ZERO;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Next-state logic; the counter restarts from zero on every state entry
  // and saturates at the acceptance point, so it can never wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = c_CNT_ZERO;
    case (r_state)
      c_ST_UP: begin
        if (w_pressed) begin
          w_state_nxt = c_ST_WAIT_DN;
        end
      end
      c_ST_WAIT_DN: begin
        if (!w_pressed) begin
          // Bounce: fall back without accepting the press.
          w_state_nxt = c_ST_UP;
        end else if (r_cnt == c_CNT_MAX) begin
          w_state_nxt = c_ST_DOWN;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      c_ST_DOWN: begin
        if (!w_pressed) begin
          w_state_nxt = c_ST_WAIT_UP;
        end
      end
      c_ST_WAIT_UP: begin
        if (w_pressed) begin
          // Release bounce: stay pressed, no fresh pulse.
          w_state_nxt = c_ST_DOWN;
        end else if (r_cnt == c_CNT_MAX) begin
          w_state_nxt = c_ST_UP;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = c_ST_UP;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs change on the
  // acceptance edge itself; only a WAIT_DN -> DOWN transition pulses.
  always_comb begin
    w_pulse_nxt = (r_state == c_ST_WAIT_DN) && (w_state_nxt == c_ST_DOWN);
    w_level_nxt = (w_state_nxt == c_ST_DOWN) || (w_state_nxt == c_ST_WAIT_UP);
  end

  assign key_pulse = r_pulse;
  assign key_level = r_level;

endmodule : key_debounce_one
`default_nettype wire

// File: rtl/key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_pulse
// Brief    : Push-button front end. Synchronises and debounces NKEYS keys
//            independently, emitting a one-cycle press pulse per key (for the
//            key-toggle stage) and the debounced key level (1 = pressed).
//            Simultaneous pulses are passed through unprioritised.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_pulse
  import key_debounce_pulse_pkg::*;
#(
  parameter int NKEYS           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [NKEYS-1:0] Key_In,
  output logic [NKEYS-1:0] Key_Pulse,
  output logic [NKEYS-1:0] Key_Level
);

  // One fully independent conditioning channel per key.
  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce_one #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_key (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .key_raw   (Key_In[i]),
      .key_pulse (Key_Pulse[i]),
      .key_level (Key_Level[i])
    );
  end

endmodule : key_debounce_pulse
`default_nettype wire

// File: tb/tb_key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_pulse
// Brief    : Self-checking bench for key_debounce_pulse (NKEYS=5,
//            DEBOUNCE_CYCLES=4, active-low keys). Directed scenarios followed
//            by random key activity, compared against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_pulse;

  localparam int NK = 5;
  localparam int DC = 4;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic [NK-1:0] Key_In;
  logic [NK-1:0] Key_Pulse;
  logic [NK-1:0] Key_Level;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: two-edge sampling delay of the raw pins, the debounced
  // level, and per key the number of consecutive edges on which the sampled
  // key disagreed with the debounced level.
  logic [NK-1:0] m_d1, m_d2, m_level, m_pulse;
  int            m_run [NK];

  key_debounce_pulse #(
    .NKEYS           (NK),
    .DEBOUNCE_CYCLES (DC),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Key_In    (Key_In),
    .Key_Pulse (Key_Pulse),
    .Key_Level (Key_Level)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d1    = '1;
    m_d2    = '1;
    m_level = '0;
    m_pulse = '0;
    for (int k = 0; k < NK; k++) m_run[k] = 0;
  endtask

  // A level change is accepted once the sampled key has disagreed with the
  // current level on DC+1 consecutive edges; accepting a press pulses.
  task automatic model_edge();
    logic [NK-1:0] p;
    p       = ~m_d2;
    m_pulse = '0;
    for (int k = 0; k < NK; k++) begin
      if (p[k] != m_level[k]) begin
        m_run[k]++;
        if (m_run[k] == DC + 1) begin
          m_run[k]   = 0;
          m_level[k] = p[k];
          m_pulse[k] = p[k];
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = Key_In;
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    if (RSTn) model_edge();
    #1;
    check("pulse_vs_model", Key_Pulse, m_pulse);
    check("level_vs_model", Key_Level, m_level);
  endtask

  // Assert reset away from an edge, hold it, release at a falling edge.
  task automatic apply_reset(input int hold);
    RSTn = 1'b0;
    model_reset();
    #1;
    check("reset_pulse_clear", Key_Pulse, '0);
    check("reset_level_clear", Key_Level, '0);
    repeat (hold) tick();
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  initial begin
    int pulses2;
    int pulses0;
    int pulses3;

    // 1. Reset behaviour, then release with all keys up.
    Key_In = '0;
    RSTn   = 1'b0;
    model_reset();
    repeat (3) begin
      tick();
      check("s1_pulse_in_reset", Key_Pulse, '0);
      check("s1_level_in_reset", Key_Level, '0);
    end
    Key_In = 5'b11111;
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (20) begin
      tick();
      check("s1_pulse_idle", Key_Pulse, '0);
      check("s1_level_idle", Key_Level, '0);
    end

    // 2. Clean press on key 0: pulse on the 7th edge (E0+6).
    Key_In[0] = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (i < 6) check("s2_no_early_pulse", Key_Pulse, 5'b00000);
    end
    check("s2_pulse", Key_Pulse, 5'b00001);
    check("s2_level", Key_Level, 5'b00001);
    repeat (13) begin
      tick();
      check("s2_no_repeat", Key_Pulse, 5'b00000);
    end

    // 3. Bouncy press on key 2, then held low from edge E1.
    pulses2 = 0;
    for (int i = 0; i < 6; i++) begin
      Key_In[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        tick();
        pulses2 += int'(Key_Pulse[2]);
      end
    end
    Key_In[2] = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      pulses2 += int'(Key_Pulse[2]);
    end
    check("s3_pulse_at_E1p6", Key_Pulse, 5'b00100);
    repeat (6) begin
      tick();
      pulses2 += int'(Key_Pulse[2]);
    end
    check("s3_single_pulse", 5'(pulses2), 5'd1);

    // 4. Short glitch on key 3 is rejected.
    pulses3 = 0;
    Key_In[3] = 1'b0;
    repeat (3) begin
      tick();
      pulses3 += int'(Key_Pulse[3]);
    end
    Key_In[3] = 1'b1;
    repeat (10) begin
      tick();
      pulses3 += int'(Key_Pulse[3]);
    end
    check("s4_no_pulse", 5'(pulses3), 5'd0);
    check("s4_level", Key_Level, 5'b00101);

    // 5. Keys 4 and 1 pressed before the same edge.
    Key_In[4] = 1'b0;
    Key_In[1] = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (i < 6) check("s5_no_early_pulse", Key_Pulse, 5'b00000);
    end
    check("s5_pulse", Key_Pulse, 5'b10010);
    check("s5_level", Key_Level, 5'b10111);
    tick();
    check("s5_pulse_one_cycle", Key_Pulse, 5'b00000);

    // 6a. Short release then re-press of key 0: no second pulse.
    pulses0 = 0;
    Key_In[0] = 1'b1;
    repeat (2) begin
      tick();
      pulses0 += int'(Key_Pulse[0]);
    end
    Key_In[0] = 1'b0;
    repeat (10) begin
      tick();
      pulses0 += int'(Key_Pulse[0]);
    end
    check("s6_no_repress_pulse", 5'(pulses0), 5'd0);
    check("s6_level_held", Key_Level, 5'b10111);

    // Full release of keys 0 and 2; keys 1 and 4 stay down.
    Key_In = 5'b01101;
    repeat (12) tick();
    check("s6_release_level", Key_Level, 5'b10010);
    check("s6_release_no_pulse", Key_Pulse, 5'b00000);

    // 6b. Reset during key 0's WAIT_DN with keys 0,1,4 held.
    Key_In[0] = 1'b0;
    repeat (3) tick();
    apply_reset(2);
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (i < 6) check("s6_post_reset_quiet", Key_Pulse, 5'b00000);
    end
    check("s6_post_reset_pulse", Key_Pulse, 5'b10011);
    check("s6_post_reset_level", Key_Level, 5'b10011);

    // 7. Random key activity with occasional resets.
    for (int t = 0; t < 600; t++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 7) == 0) Key_In[k] = ~Key_In[k];
      end
      if ($urandom_range(0, 249) == 0) apply_reset(2);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_key_debounce_pulse
`default_nettype wire
